branch_rs: RTL
==============

# branch_rs

Branch reservation station: buffers decoded conditional-branch / JAL / JALR micro-ops, waits for their register operands via common-data-bus (CDB) wakeup, and dispatches them in program order to the branch execution unit. It sits between the dispatch stage and the branch execution unit. It drives that unit's `start`, 106-bit `rs` and `pc` inputs, and consumes its `finish` pulse. At most one branch is in flight in the execution unit at a time.

## Interface
- `DEPTH`, 4: entry count, power of two, 2..16.
- `TAG_W`, 5: operand tag width; a not-ready source carries its tag in `in_srcN[TAG_W-1:0]`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: dispatch offers an entry.
- `in_ready` out 1: `count < DEPTH`; an entry is accepted on `in_valid && in_ready && !flush`.
- `in_op` in 5: branch op code; `[4:3]` = 00 conditional, 10 JAL, 11 JALR; `[2:0]` = funct3.
- `in_rd` in 5: destination register.
- `in_src1_ready`, `in_src2_ready` in 1 each: the source holds a value (1) or a tag (0).
- `in_src1`, `in_src2` in 32 each: operand value, or tag in the low bits.
- `in_imm` in 32: sign-extended offset.
- `in_pc` in 32: PC of the branch.
- `cdb_valid` in 1: result broadcast.
- `cdb_tag` in TAG_W: broadcast tag.
- `cdb_data` in 32: broadcast value.
- `flush` in 1: squash all entries; a misprediction recovery.
- `start` out 1: one-cycle issue pulse to the execution unit.
- `rs` out 106: `{op, rd, src1, src2, imm}`; `op` is bits 105:101, `imm` is bits 31:0.
- `pc` out 32: PC of the issued entry.
- `finish` in 1: the execution unit has completed the in-flight branch.
- `count` out $clog2(DEPTH+1): number of occupied entries.

## Operation
- Storage is a circular FIFO with `head`/`tail` pointers of width $clog2(DEPTH) and a separate `count`.
  - Pointers wrap from DEPTH-1 to 0.
  - Full when `count == DEPTH`; empty when `count == 0`.
- Each entry holds: `op`, `rd`, `imm`, `pc`, and for each source a `rdy` flag plus a 32-bit value-or-tag field.
- Wakeup:
  - Every cycle with `cdb_valid`, each valid entry whose source has `rdy == 0` and `tag == cdb_tag` latches `cdb_data` and sets `rdy`.
  - Both sources of one entry may wake on the same broadcast.
- Enqueue capture:
  - An entry enqueued with `in_srcN_ready == 0` and `in_srcN[TAG_W-1:0] == cdb_tag` while `cdb_valid` is stored already ready, holding `cdb_data`.
  - This capture is mandatory; without it the wakeup would be lost.
- Issue condition: head valid, both sources ready, `busy == 0`, `flush == 0`. When it holds, at the next edge:
  - `start` = 1 and `rs`/`pc` load the head entry;
  - head pops and `busy` = 1.
- `busy` clears on `finish`. A `finish` arriving while `busy == 0` is ignored.
- Only the head may issue. Younger ready entries wait, which keeps branches strictly in order.
- Enqueue and issue in the same cycle are legal; `count` stays unchanged. Acceptance is not allowed by a same-cycle pop while full.
- Flush:
  - Next edge: `count`, `head`, `tail` = 0, all entries invalid, `busy` = 0, `start` = 0.
  - A concurrent `in_valid` is dropped, and a concurrent issue is suppressed.
  - `rs`/`pc` hold their last values.
- `finish` and issue in the same cycle: `busy` clears and the head may issue on the following evaluation.

## Timing
- Reset values: `start` 0, `rs` 0, `pc` 0, `count` 0, all entries invalid, `busy` 0. `in_ready` is 1 while in reset.
- `start` is a registered, single-cycle pulse. `rs`/`pc` are registered, change only with `start`, and hold between issues.
- Latency:
  - An entry enqueued at edge N with both sources ready, into an empty station with `busy == 0`, gives `start` high in the cycle after edge N+1.
  - CDB wakeup sampled at edge M gives `start` after edge M+1.
- Reset mid-operation discards everything immediately. The execution unit's pending `finish` is then ignored.

## Configuration
- `BRANCH_RS_ISSUE_BYPASS_EN` defined:
  - The issue check treats a head source as ready if it matches the current `cdb_valid`/`cdb_tag`.
  - `rs` is loaded with `cdb_data` for that source, so `start` rises after edge M instead of M+1.
- Undefined: wakeup and issue are strictly separated by one register stage, giving the latency above.

## Test plan
- Reset, then enqueue BEQ (`op` 5'b00000, `rd` 0, `src1 = src2` = 7, `imm` 16, `pc` 0x100), both ready -> one `start` pulse two edges later. `rs` = {5'b00000, 5'd0, 32'd7, 32'd7, 32'd16}, `pc` = 0x100.
- Enqueue BNE with `src2` waiting on tag 3, then `cdb_valid`, tag 3, data 0x55 -> `start` after edge M+1 (after edge M with the macro), with `src2` = 0x55 in `rs`.
- Enqueue while `cdb_valid`, tag 9, data 0xAA matches the entry's src1 tag -> entry issues with `src1` = 0xAA and no further broadcast needed.
- Fill 4 entries with `finish` held low -> `in_ready` = 0, `count` = 4, only one `start`. Pulse `finish` -> next `start`, `count` 3, `in_ready` 1, correct head wrap after 4+ pushes.
- Head not ready, entry 2 ready -> no `start` until head wakes. Then entries issue in order, one per `finish`.
- With 3 entries and `busy`, assert `flush` with `in_valid` -> `count` 0, `start` 0, input dropped. A late `finish` is ignored, and the next enqueue issues normally.

Source files
------------

// File: rtl/branch_rs_if.sv
// Signal bundle between dispatch, CDB, branch execution unit and branch_rs.
interface branch_rs_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op;
  logic [4:0]        in_rd;
  logic              in_src1_ready;
  logic              in_src2_ready;
  logic [31:0]       in_src1;
  logic [31:0]       in_src2;
  logic [31:0]       in_imm;
  logic [31:0]       in_pc;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [31:0]       cdb_data;
  logic              flush;
  logic              start;
  logic [105:0]      rs;
  logic [31:0]       pc;
  logic              finish;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_op, in_rd, in_src1_ready, in_src2_ready, in_src1, in_src2,
           in_imm, in_pc, cdb_valid, cdb_tag, cdb_data, flush, finish,
    input  in_ready, start, rs, pc, count
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_src1_ready, in_src2_ready, in_src1, in_src2,
           in_imm, in_pc, cdb_valid, cdb_tag, cdb_data, flush, finish,
    output in_ready, start, rs, pc, count
  );
endinterface

// File: rtl/branch_rs.sv
// Branch reservation station: in-order FIFO of branch micro-ops with CDB
// operand wakeup, issuing one branch at a time to the branch unit.
// Optional macro BRANCH_RS_ISSUE_BYPASS_EN lets the head issue on the same
// cycle its last operand is broadcast.
module branch_rs #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
) (
  input logic        clk,
  input logic        reset,
  branch_rs_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_rdy1;
  logic [DEPTH-1:0] r_rdy2;
  logic [4:0]       r_ent_op   [DEPTH];
  logic [4:0]       r_ent_rd   [DEPTH];
  logic [31:0]      r_ent_src1 [DEPTH];
  logic [31:0]      r_ent_src2 [DEPTH];
  logic [31:0]      r_ent_imm  [DEPTH];
  logic [31:0]      r_ent_pc   [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_start;
  logic [105:0]     r_rs;
  logic [31:0]      r_pc;

  logic [DEPTH-1:0] w_wake1;
  logic [DEPTH-1:0] w_wake2;
  logic             w_in_ready;
  logic             w_push;
  logic             w_cap1;
  logic             w_cap2;
  logic             w_h_rdy1;
  logic             w_h_rdy2;
  logic [31:0]      w_h_val1;
  logic [31:0]      w_h_val2;
  logic             w_issue;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_in_ready = (r_count < CNT_W'(DEPTH));
  assign w_push     = bus.in_valid && w_in_ready && !bus.flush;
  // A broadcast arriving with the enqueue must be captured or it is lost.
  assign w_cap1 = !bus.in_src1_ready && bus.cdb_valid && (bus.in_src1[TAG_W-1:0] == bus.cdb_tag);
  assign w_cap2 = !bus.in_src2_ready && bus.cdb_valid && (bus.in_src2[TAG_W-1:0] == bus.cdb_tag);

  // Per-entry CDB tag match for sources still waiting.
  always_comb begin
    w_wake1 = '0;
    w_wake2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_wake1[PTR_W'(i)] = bus.cdb_valid && r_valid[PTR_W'(i)] && !r_rdy1[PTR_W'(i)] &&
                           (r_ent_src1[PTR_W'(i)][TAG_W-1:0] == bus.cdb_tag);
      w_wake2[PTR_W'(i)] = bus.cdb_valid && r_valid[PTR_W'(i)] && !r_rdy2[PTR_W'(i)] &&
                           (r_ent_src2[PTR_W'(i)][TAG_W-1:0] == bus.cdb_tag);
    end
  end

`ifdef BRANCH_RS_ISSUE_BYPASS_EN
  // Head operand readiness including the broadcast of this cycle.
  assign w_h_rdy1 = r_rdy1[r_head] || w_wake1[r_head];
  assign w_h_rdy2 = r_rdy2[r_head] || w_wake2[r_head];
  assign w_h_val1 = w_wake1[r_head] ? bus.cdb_data : r_ent_src1[r_head];
  assign w_h_val2 = w_wake2[r_head] ? bus.cdb_data : r_ent_src2[r_head];
`else
  // Head operand readiness from stored state only.
  assign w_h_rdy1 = r_rdy1[r_head];
  assign w_h_rdy2 = r_rdy2[r_head];
  assign w_h_val1 = r_ent_src1[r_head];
  assign w_h_val2 = r_ent_src2[r_head];
`endif

  // Busy state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Issue decision and busy next-state.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.flush && r_valid[r_head] && w_h_rdy1 && w_h_rdy2) begin
          w_issue     = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.flush || bus.finish) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Occupancy update; a simultaneous push and pop cancel out.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_issue})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Control flags, pointers and issue outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_rdy1  <= '0;
      r_rdy2  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_start <= 1'b0;
      r_rs    <= '0;
      r_pc    <= '0;
    end else if (bus.flush) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_start <= 1'b0;
    end else begin
      r_start <= w_issue;
      r_count <= w_count_nxt;
      r_rdy1  <= r_rdy1 | w_wake1;
      r_rdy2  <= r_rdy2 | w_wake2;
      if (w_issue) begin
        r_rs            <= {r_ent_op[r_head], r_ent_rd[r_head], w_h_val1, w_h_val2, r_ent_imm[r_head]};
        r_pc            <= r_ent_pc[r_head];
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_rdy1[r_tail]  <= bus.in_src1_ready || w_cap1;
        r_rdy2[r_tail]  <= bus.in_src2_ready || w_cap2;
        r_tail          <= r_tail + PTR_W'(1);
      end
    end
  end

  // Entry payload: written on enqueue, source fields refreshed on wakeup.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wake1[PTR_W'(i)]) r_ent_src1[PTR_W'(i)] <= bus.cdb_data;
      if (w_wake2[PTR_W'(i)]) r_ent_src2[PTR_W'(i)] <= bus.cdb_data;
    end
    if (w_push) begin
      r_ent_op[r_tail]   <= bus.in_op;
      r_ent_rd[r_tail]   <= bus.in_rd;
      r_ent_imm[r_tail]  <= bus.in_imm;
      r_ent_pc[r_tail]   <= bus.in_pc;
      r_ent_src1[r_tail] <= w_cap1 ? bus.cdb_data : bus.in_src1;
      r_ent_src2[r_tail] <= w_cap2 ? bus.cdb_data : bus.in_src2;
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.start    = r_start;
  assign bus.rs       = r_rs;
  assign bus.pc       = r_pc;
  assign bus.count    = r_count;

endmodule
